rf_dump_reader: RTL and testbench

Debug/trace block sitting on a spare read port of the 32x32 register file. On a start pulse it walks a latched register index range and issues one combinational read per index. Each read value is presented, tagged with its index, on a valid/ready stream toward the debug/trace sink. It is the reader-side counterpart to the writeback path: it consumes register state without ever writing it.

---
 rtl/rf_dump_reader.sv | 159 +++++++++++++++
 tb/tb_rf_dump_reader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks a latched register index range on a spare register
// file read port and streams each value, tagged with its index, to a debug
// or trace sink. It only reads register state and never writes it.
//
// Stream handshake: a beat is held on data_o/idx_o/last_o with valid_o high
// and does not change until the cycle in which valid_o && ready_i are both
// high; the beat is accepted at that clock edge. An abort in the same cycle
// cancels the dump, and that beat is not counted.
module rf_dump_reader #(
   parameter int NREG = 32,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   input  logic [AW-1:0] first_i,
   input  logic [AW-1:0] last_i,
   input  logic          abort_i,
   output logic [AW-1:0] rf_addr_o,
   input  logic [DW-1:0] rf_data_i,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [DW-1:0] data_o,
   output logic [AW-1:0] idx_o,
   output logic          last_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          aborted_o,
   output logic [AW:0]   beat_cnt_o
);

   typedef enum logic [1:0] {IDLE, READ, SEND, FIN} state_t;

   // Highest legal index. The walk also stops here, so ptr can never wrap.
   localparam logic [AW-1:0] PTR_MAX = AW'(NREG - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [AW-1:0] first_q, first_d;
   logic [AW-1:0] last_q, last_d;
   logic [DW-1:0] data_q, data_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          last_beat_q, last_beat_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;
   logic          aborted_q, aborted_d;
   logic [AW:0]   beat_cnt_q, beat_cnt_d;

   // Next-state and datapath: hold everything by default; pulses default low.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      first_d     = first_q;
      last_d      = last_q;
      data_d      = data_q;
      idx_d       = idx_q;
      last_beat_d = last_beat_q;
      valid_d     = valid_q;
      done_d      = 1'b0;
      aborted_d   = 1'b0;
      beat_cnt_d  = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               first_d    = first_i;
               last_d     = last_i;
               ptr_d      = first_i;
               beat_cnt_d = '0;
               // An inverted range is empty: go straight to FIN for done_o.
               state_d    = (first_i > last_i) ? FIN : READ;
            end
         end
         READ: begin
            if (abort_i) begin
               valid_d     = 1'b0;
               last_beat_d = 1'b0;
               aborted_d   = 1'b1;
               state_d     = IDLE;
            end else begin
               // x0 is architecturally zero whatever the array holds.
               data_d      = (ptr_q == '0) ? '0 : rf_data_i;
               idx_d       = ptr_q;
               last_beat_d = (ptr_q == last_q);
               valid_d     = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (abort_i) begin
               valid_d     = 1'b0;
               last_beat_d = 1'b0;
               aborted_d   = 1'b1;
               state_d     = IDLE;
            end else if (valid_q && ready_i) begin
               beat_cnt_d  = beat_cnt_q + 1'b1;
               valid_d     = 1'b0;
               last_beat_d = 1'b0;
               if (ptr_q == last_q || ptr_q == PTR_MAX) begin
                  state_d = FIN;
               end else begin
                  ptr_d   = ptr_q + AW'(1);
                  state_d = READ;
               end
            end
         end
         FIN: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         first_q     <= '0;
         last_q      <= '0;
         data_q      <= '0;
         idx_q       <= '0;
         last_beat_q <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         first_q     <= first_d;
         last_q      <= last_d;
         data_q      <= data_d;
         idx_q       <= idx_d;
         last_beat_q <= last_beat_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         aborted_q   <= aborted_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   // Read address is only driven while a walk is in flight.
   always_comb begin
      rf_addr_o = '0;
      if (state_q == READ || state_q == SEND) rf_addr_o = ptr_q;
   end

   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign idx_o      = idx_q;
   assign last_o     = last_beat_q;
   assign busy_o     = (state_q != IDLE);
   assign done_o     = done_q;
   assign aborted_o  = aborted_q;
   assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: table of dump ranges with hand-computed beat
// counts, plus hand-written sequences for empty range, abort and reset.
module tb_rf_dump_reader;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_i;
   logic [AW-1:0] first_i;
   logic [AW-1:0] last_i;
   logic          abort_i;
   logic [AW-1:0] rf_addr_o;
   logic [DW-1:0] rf_data_i;
   logic          valid_o;
   logic          ready_i;
   logic [DW-1:0] data_o;
   logic [AW-1:0] idx_o;
   logic          last_o;
   logic          busy_o;
   logic          done_o;
   logic          aborted_o;
   logic [AW:0]   beat_cnt_o;

   logic [DW-1:0] rf [32];
   assign rf_data_i = rf[rf_addr_o];

   int n_vec = 0;
   int n_err = 0;

   rf_dump_reader #(.NREG(32), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .first_i(first_i),
      .last_i(last_i), .abort_i(abort_i), .rf_addr_o(rf_addr_o),
      .rf_data_i(rf_data_i), .valid_o(valid_o), .ready_i(ready_i),
      .data_o(data_o), .idx_o(idx_o), .last_o(last_o), .busy_o(busy_o),
      .done_o(done_o), .aborted_o(aborted_o), .beat_cnt_o(beat_cnt_o)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] i);
      return (i == 0) ? 32'h0 : (32'h1000_0000 + 32'(i));
   endfunction

   typedef struct {
      logic [AW-1:0] f;
      logic [AW-1:0] l;
      int            stall_beat;
      int            stall_len;
      int            exp_beats;
   } vec_t;

   // Run one dump with all inputs driven and outputs sampled on negedge.
   task automatic run_dump(input vec_t v);
      int beats = 0;
      int stalled = 0;
      int dones = 0;
      int first_valid = -1;
      bit finished = 0;
      start_i = 1'b1; first_i = v.f; last_i = v.l; ready_i = 1'b1;
      for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
         @(negedge clk);
         start_i = 1'b0;
         ready_i = 1'b1;
         if (done_o) dones++;
         if (valid_o) begin
            if (first_valid < 0) first_valid = cyc;
            check("beat_idx", idx_o, 64'(v.f + beats));
            check("beat_data", data_o, exp_data(AW'(v.f + beats)));
            check("beat_last", last_o, (AW'(v.f + beats) == v.l));
            if (beats == v.stall_beat && stalled < v.stall_len) begin
               ready_i = 1'b0;
               stalled++;
            end else begin
               beats++;
            end
         end
         if (dones > 0 && !done_o) finished = 1;
      end
      if (!finished) check("dump_timeout", 0, 1);
      check("beats_seen", beats, v.exp_beats);
      check("beat_cnt_o", beat_cnt_o, v.exp_beats);
      check("done_pulses", dones, 1);
      check("stall_cycles", stalled, (v.stall_beat >= 0) ? v.stall_len : 0);
      if (v.exp_beats > 0) check("first_latency", first_valid, 2);
      check("busy_after", busy_o, 0);
   endtask

   vec_t vecs[5];

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + i;
      reset = 1'b1; start_i = 1'b0; first_i = '0; last_i = '0;
      abort_i = 1'b0; ready_i = 1'b0;
      repeat (3) @(negedge clk);
      // Reset values
      check("rst_valid", valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_addr", rf_addr_o, 0);
      check("rst_cnt", beat_cnt_o, 0);
      check("rst_data", data_o, 0);
      check("rst_done", {done_o, aborted_o, last_o}, 0);
      reset = 1'b0;
      @(negedge clk);

      vecs[0] = '{f: 5'd0,  l: 5'd31, stall_beat: -1, stall_len: 0, exp_beats: 32};
      vecs[1] = '{f: 5'd5,  l: 5'd7,  stall_beat: 1,  stall_len: 4, exp_beats: 3};
      vecs[2] = '{f: 5'd30, l: 5'd31, stall_beat: 0,  stall_len: 2, exp_beats: 2};
      vecs[3] = '{f: 5'd31, l: 5'd31, stall_beat: -1, stall_len: 0, exp_beats: 1};
      vecs[4] = '{f: 5'd12, l: 5'd15, stall_beat: 3,  stall_len: 1, exp_beats: 4};
      for (int k = 0; k < 5; k++) begin
         run_dump(vecs[k]);
         @(negedge clk);
      end

      // Index 0 is forced to zero even if the array holds garbage
      rf[0] = 32'hDEAD_BEEF;
      run_dump('{f: 5'd0, l: 5'd0, stall_beat: -1, stall_len: 0, exp_beats: 1});
      rf[0] = 32'h0;

      // Empty range: no beats, done two cycles after start
      start_i = 1'b1; first_i = 5'd9; last_i = 5'd3;
      @(negedge clk);
      start_i = 1'b0;
      check("empty_valid1", valid_o, 0);
      check("empty_done1", done_o, 0);
      @(negedge clk);
      check("empty_valid2", valid_o, 0);
      check("empty_done2", done_o, 1);
      check("empty_cnt", beat_cnt_o, 0);
      @(negedge clk);
      check("empty_done3", done_o, 0);

      // Abort coinciding with the fifth handshake; stray start ignored
      begin
         int beats = 0;
         bit aborted = 0;
         start_i = 1'b1; first_i = 5'd0; last_i = 5'd31; ready_i = 1'b1;
         for (int cyc = 0; cyc < 100 && !aborted; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (cyc == 5) begin
               start_i = 1'b1; first_i = 5'd20; last_i = 5'd21;
            end
            if (valid_o) begin
               check("abort_idx", idx_o, beats);
               if (beats == 4) begin
                  abort_i = 1'b1;
                  aborted = 1;
               end else begin
                  beats++;
               end
            end
         end
         if (!aborted) check("abort_timeout", 0, 1);
         @(negedge clk);
         abort_i = 1'b0; start_i = 1'b0;
         check("abort_busy", busy_o, 0);
         check("abort_valid", {valid_o, last_o}, 0);
         check("abort_pulse", aborted_o, 1);
         check("abort_nodone", done_o, 0);
         check("abort_cnt", beat_cnt_o, 4);
         repeat (3) begin
            @(negedge clk);
            check("abort_quiet", {done_o, aborted_o, busy_o}, 0);
         end
      end

      // Reset while waiting in SEND at index 10
      begin
         bit hit = 0;
         start_i = 1'b1; first_i = 5'd0; last_i = 5'd31; ready_i = 1'b1;
         for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (valid_o && idx_o == 5'd10) begin
               ready_i = 1'b0;
               reset = 1'b1;
               hit = 1;
            end
         end
         if (!hit) check("reset_timeout", 0, 1);
         @(negedge clk);
         reset = 1'b0;
         check("mid_rst_busy", busy_o, 0);
         check("mid_rst_flags", {valid_o, last_o, done_o, aborted_o}, 0);
         check("mid_rst_data", {data_o, idx_o, rf_addr_o, beat_cnt_o}, 0);
         @(negedge clk);
         check("mid_rst_nopulse", {done_o, aborted_o}, 0);
         run_dump('{f: 5'd10, l: 5'd10, stall_beat: -1, stall_len: 0, exp_beats: 1});
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
